// File: rtl/pipe_latch_skid.sv
// Two-entry pipeline latch with skid buffer: main register drives the output,
// skid register absorbs one beat so in_ready never depends on out_ready.
module pipe_latch_skid #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned FIELDS = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FIELDS*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FIELDS*WIDTH-1:0] out_data,
  input  logic                    flush,
  output logic [1:0]              occupancy,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam int unsigned P = FIELDS * WIDTH;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]   state;
  logic [1:0]   state_nxt;
  logic [P-1:0] main_q;
  logic [P-1:0] skid_q;
  logic         load_main;
  logic         load_skid;
  logic         main_from_skid;
  logic         in_acc;
  logic         out_acc;

  // Handshake decodes come straight from the state register.
  assign in_ready  = (state != TWO) && !reset;
  assign out_valid = (state == ONE) || (state == TWO);
  assign occupancy = state;
  assign out_data  = main_q;
  assign in_acc    = in_valid && in_ready;
  assign out_acc   = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and data-register load enables; flush overrides everything.
  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (in_acc) begin
          state_nxt = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (in_acc && out_acc) begin
          load_main = 1'b1;
        end else if (in_acc) begin
          state_nxt = TWO;
          load_skid = 1'b1;
        end else if (out_acc) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (out_acc) begin
          state_nxt      = ONE;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= main_from_skid ? skid_q : in_data;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

  // Saturating count of back-pressured cycles; flush does not touch it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
